// File: rtl/arb_defs.sv
// rtl/arb_defs.sv - shared state/owner encodings and sizing helper for the memory port arbiter
package arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - loadable down-counter timing the m_en window of one access
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   load       load load_val (takes priority over dec)
//   load_val   value loaded on load
//   dec        decrement by one, holding at zero
//   zero       count is zero
module arb_wait_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between IF and MEM pipeline stages
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   if_req/if_addr                    instruction fetch request (held until if_ready)
//   if_ready/if_rdata                 fetch completion pulse and fetched word
//   mem_req/mem_we/mem_addr/mem_wdata data access request (held until mem_ready)
//   mem_ready/mem_rdata               data completion pulse and read data
//   m_en/m_we/m_addr/m_wdata/m_rdata  memory-side interface, m_rdata sampled in last m_en cycle
//   busy                              an access is in flight
//   grant_data                        owner of the current/last access (1 = MEM)
module mem_port_arbiter
    import arb_defs::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              grant_data
);

    localparam int WC_W = cnt_width(WAIT_CYCLES - 1);
    localparam int SC_W = cnt_width(STARVE_LIMIT);
    localparam logic [WC_W-1:0] WAIT_LOAD  = WC_W'(WAIT_CYCLES - 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic            grant_mem;
    logic            grant_if;
    logic            grant;
    logic            acc_done;
    logic            starve_hit;
    logic            wait_zero;
    logic [SC_W-1:0] starve_cnt;

    // IF is forced only while it is actually waiting and MEM has used up its run.
    assign starve_hit = if_req && (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX);
    assign grant      = grant_mem | grant_if;

    arb_wait_counter #(
        .W (WC_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (grant),
        .load_val (WAIT_LOAD),
        .dec      (state == ST_ACCESS),
        .zero     (wait_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        acc_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_req && !starve_hit) begin
                    grant_mem = 1'b1;
                    state_nxt = ST_ACCESS;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wait_zero) begin
                    acc_done  = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Ready is raised on the edge that leaves ACCESS so it is high for the
    // single RESP cycle; rdata is written on that same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            busy       <= 1'b0;
            grant_data <= OWN_IF;
            starve_cnt <= '0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            busy      <= (state_nxt != ST_IDLE);

            if (grant_mem) begin
                m_en       <= 1'b1;
                m_we       <= mem_we;
                m_addr     <= mem_addr;
                m_wdata    <= mem_wdata;
                grant_data <= OWN_MEM;
                if (if_req) begin
                    if (starve_cnt != STARVE_MAX) begin
                        starve_cnt <= starve_cnt + SC_W'(1);
                    end
                end else begin
                    starve_cnt <= '0;
                end
            end else if (grant_if) begin
                m_en       <= 1'b1;
                m_we       <= 1'b0;
                m_addr     <= if_addr;
                grant_data <= OWN_IF;
                starve_cnt <= '0;
            end

            if (acc_done) begin
                m_en <= 1'b0;
                m_we <= 1'b0;
                if (grant_data == OWN_MEM) begin
                    mem_ready <= 1'b1;
                    if (!m_we) begin
                        mem_rdata <= m_rdata;
                    end
                end else begin
                    if_ready <= 1'b1;
                    if_rdata <= m_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed checks of mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;

    localparam int W     = 2;
    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        if_req, if_ready, mem_req, mem_we, mem_ready;
    logic        m_en, m_we, busy, grant_data;
    logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] m_addr, m_wdata, m_rdata;

    logic        rst2;
    logic        if_req2, if_ready2, mem_req2, mem_we2, mem_ready2;
    logic        m_en2, m_we2, busy2, grant_data2;
    logic [31:0] if_addr2, if_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
    logic [31:0] m_addr2, m_wdata2, m_rdata2;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy), .grant_data(grant_data)
    );

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1), .STARVE_LIMIT(0)
    ) dut2 (
        .clk(clk), .rst(rst2),
        .if_req(if_req2), .if_addr(if_addr2), .if_ready(if_ready2), .if_rdata(if_rdata2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_ready(mem_ready2), .mem_rdata(mem_rdata2),
        .m_en(m_en2), .m_we(m_we2), .m_addr(m_addr2), .m_wdata(m_wdata2), .m_rdata(m_rdata2),
        .busy(busy2), .grant_data(grant_data2)
    );

    function automatic logic [31:0] data2(input logic [31:0] a);
        return (a ^ 32'h0BADF00D) + {a[15:0], a[31:16]};
    endfunction

    assign m_rdata2 = data2(m_addr2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    // transaction model
    bit          active;
    bit          g_own, g_we, last_own;
    int          g_cyc, free_at, scnt;
    logic [31:0] g_addr, g_wdata, rd_last, exp_if_rd, exp_mem_rd;
    bit          if_rdy_seen, mem_rdy_seen;
    int          n_if_rdy, n_mem_rdy, last_if_rdy_cyc, last_mem_rdy_cyc;
    bit          ord_q[$];

    // requester agents
    bit          rnd, if_pend, mem_pend, if_go, mem_go, mem_go_we, mem_repeat;
    logic [31:0] if_go_addr, mem_go_addr, mem_go_wdata, fixed_rd;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        bit in_acc, in_resp, own;
        if (!rst) begin
            chk("rst_m_en", m_en, 0);          chk("rst_m_we", m_we, 0);
            chk("rst_m_addr", m_addr, 0);      chk("rst_m_wdata", m_wdata, 0);
            chk("rst_if_ready", if_ready, 0);  chk("rst_mem_ready", mem_ready, 0);
            chk("rst_if_rdata", if_rdata, 0);  chk("rst_mem_rdata", mem_rdata, 0);
            chk("rst_busy", busy, 0);          chk("rst_grant", grant_data, 0);
            active = 0; free_at = 0; scnt = 0; last_own = 0;
            exp_if_rd = '0; exp_mem_rd = '0; if_rdy_seen = 0; mem_rdy_seen = 0;
            return;
        end
        in_acc  = active && (cyc >= g_cyc + 1) && (cyc <= g_cyc + W);
        in_resp = active && (cyc == g_cyc + W + 1);
        if (in_acc && cyc == g_cyc + W) rd_last = m_rdata;
        if (in_resp) begin
            if (!g_own) exp_if_rd = rd_last;
            else if (!g_we) exp_mem_rd = rd_last;
        end
        chk("m_en", m_en, in_acc);
        chk("m_we", m_we, in_acc && g_we);
        chk("busy", busy, in_acc || in_resp);
        chk("if_ready", if_ready, in_resp && !g_own);
        chk("mem_ready", mem_ready, in_resp && g_own);
        chk("grant_data", grant_data, last_own);
        chk("if_rdata", if_rdata, exp_if_rd);
        chk("mem_rdata", mem_rdata, exp_mem_rd);
        if (in_acc) begin
            chk("m_addr", m_addr, g_addr);
            if (g_we) chk("m_wdata", m_wdata, g_wdata);
        end
        if_rdy_seen  = if_ready;
        mem_rdy_seen = mem_ready;
        if (if_ready)  begin n_if_rdy++;  last_if_rdy_cyc = cyc;  ord_q.push_back(1'b0); end
        if (mem_ready) begin n_mem_rdy++; last_mem_rdy_cyc = cyc; ord_q.push_back(1'b1); end
        if (in_resp) active = 0;
        // One access occupies W+2 cycles; the next decision is taken on the first free cycle.
        if (!active && cyc >= free_at && (if_req || mem_req)) begin
            own = mem_req && !(if_req && LIMIT != 0 && scnt == LIMIT);
            if (own && if_req) scnt = (scnt < LIMIT) ? scnt + 1 : LIMIT;
            else scnt = 0;
            active = 1; g_cyc = cyc; free_at = cyc + W + 2;
            g_own = own; g_we = own && mem_we; last_own = own;
            g_addr = own ? mem_addr : if_addr; g_wdata = mem_wdata;
        end
    endtask

    task automatic drive();
        if (!rst) begin
            if_req = 0; mem_req = 0; if_pend = 0; mem_pend = 0; if_go = 0; mem_go = 0;
            return;
        end
        m_rdata = rnd ? $urandom : fixed_rd;
        if (if_rdy_seen) begin if_pend = 0; if_req = 0; end
        if (!if_pend && (if_go || (rnd && $urandom_range(0, 2) == 0))) begin
            if_pend = 1; if_req = 1;
            if_addr = if_go ? if_go_addr : $urandom;
            if_go = 0;
        end else if (rnd && if_pend && active && !g_own && $urandom_range(0, 3) == 0) begin
            if_req = 0; if_addr = $urandom;
        end
        if (mem_rdy_seen) begin mem_pend = 0; mem_req = 0; end
        if (!mem_pend && (mem_go || (rnd && $urandom_range(0, 2) == 0))) begin
            mem_pend = 1; mem_req = 1;
            mem_we    = mem_go ? mem_go_we    : 1'($urandom_range(0, 1));
            mem_addr  = mem_go ? mem_go_addr  : $urandom;
            mem_wdata = mem_go ? mem_go_wdata : $urandom;
            if (!mem_repeat) mem_go = 0;
        end else if (rnd && mem_pend && active && g_own && $urandom_range(0, 3) == 0) begin
            mem_req = 0; mem_addr = $urandom; mem_wdata = $urandom; mem_we = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_rdy(input bit is_mem, input int base, input string tag);
        int k = 0;
        while (((is_mem ? n_mem_rdy : n_if_rdy) == base) && k < 40) begin
            tick();
            k++;
        end
        chk(tag, k < 40, 1);
    endtask

    initial begin
        int t0, bi, bm, nm, k2, c0, cnt_if, cnt_mem;
        int rc[3];
        bit exp_ord[6];
        exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        rst = 0; rst2 = 0;
        if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; m_rdata = 0;
        if_req2 = 0; if_addr2 = 0; mem_req2 = 0; mem_we2 = 0; mem_addr2 = 0; mem_wdata2 = 0;
        rnd = 0; if_go = 0; mem_go = 0; mem_repeat = 0; fixed_rd = 0;
        n_if_rdy = 0; n_mem_rdy = 0;
        repeat (3) tick();
        rst = 1; rst2 = 1;
        repeat (2) tick();
        chk("dut2_busy_idle", busy2, 0);

        // IF only
        fixed_rd = 32'hE3A00014;
        bm = n_mem_rdy; bi = n_if_rdy;
        if_go = 1; if_go_addr = 32'h10;
        tick(); t0 = cyc;
        wait_rdy(0, bi, "if_only_wait");
        chk("if_only_latency", last_if_rdy_cyc - t0, W + 1);
        chk("if_only_rdata", if_rdata, 32'hE3A00014);
        chk("if_only_no_mem", n_mem_rdy, bm);
        repeat (2) tick();

        // simultaneous IF and MEM read
        fixed_rd = 32'h11112222;
        bi = n_if_rdy; bm = n_mem_rdy;
        if_go = 1; if_go_addr = 32'h0;
        mem_go = 1; mem_go_we = 0; mem_go_addr = 32'h400; mem_go_wdata = 0;
        tick(); t0 = cyc;
        wait_rdy(1, bm, "simul_mem_wait");
        chk("simul_mem_latency", last_mem_rdy_cyc - t0, W + 1);
        chk("simul_mem_rdata", mem_rdata, 32'h11112222);
        wait_rdy(0, bi, "simul_if_wait");
        chk("simul_if_latency", last_if_rdy_cyc - t0, 2 * W + 3);
        repeat (2) tick();

        // MEM write leaves mem_rdata alone
        fixed_rd = 32'h5555AAAA;
        bm = n_mem_rdy;
        mem_go = 1; mem_go_we = 1; mem_go_addr = 32'h404; mem_go_wdata = 32'hDEADBEEF;
        tick();
        wait_rdy(1, bm, "write_wait");
        chk("write_keeps_rdata", mem_rdata, 32'h11112222);
        repeat (2) tick();

        // starvation guard
        ord_q.delete();
        mem_go = 1; mem_repeat = 1; mem_go_we = 0; mem_go_addr = 32'h800;
        if_go = 1; if_go_addr = 32'h20;
        k2 = 0;
        while (ord_q.size() < 6 && k2 < 80) begin tick(); k2++; end
        mem_repeat = 0; mem_go = 0;
        chk("starve_events", ord_q.size() >= 6, 1);
        for (int i = 0; i < 6; i++) if (i < ord_q.size()) chk("starve_order", ord_q[i], exp_ord[i]);
        repeat (8) tick();

        // reset in the second m_en cycle of a MEM read
        mem_go = 1; mem_go_we = 0; mem_go_addr = 32'hC00;
        tick(); t0 = cyc;
        tick();
        @(posedge clk); #1;
        cyc++;
        drive();
        chk("pre_rst_m_en", m_en, 1);
        #1 rst = 0;
        #1;
        chk("async_rst_m_en", m_en, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_m_we", m_we, 0);
        @(negedge clk);
        monitor();
        tick();
        nm = n_mem_rdy;
        rst = 1;
        repeat (6) tick();
        chk("no_ready_after_rst", n_mem_rdy, nm);
        fixed_rd = 32'hCAFEF00D;
        bi = n_if_rdy;
        if_go = 1; if_go_addr = 32'h44;
        tick();
        wait_rdy(0, bi, "post_rst_if_wait");
        chk("post_rst_if_rdata", if_rdata, 32'hCAFEF00D);
        repeat (2) tick();

        // randomized traffic
        rnd = 1;
        repeat (1500) tick();
        rnd = 0;
        repeat (20) tick();

        // WAIT_CYCLES=1 back-to-back IF
        if_req2 = 1; if_addr2 = 32'h0; c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            k2 = 0;
            do begin tick(); k2++; end while (!if_ready2 && k2 < 10);
            chk("b2b_wait", k2 < 10, 1);
            rc[k] = cyc;
            chk("b2b_rdata", if_rdata2, data2(32'(4 * k)));
            if_addr2 = 32'(4 * (k + 1));
        end
        if_req2 = 0;
        chk("b2b_first_latency", rc[0] - c0, 2);
        chk("b2b_period_1", rc[1] - rc[0], 3);
        chk("b2b_period_2", rc[2] - rc[1], 3);
        repeat (3) tick();

        // guard disabled: IF never served while MEM keeps requesting
        mem_req2 = 1; mem_we2 = 0; mem_addr2 = 32'h100;
        if_req2 = 1; if_addr2 = 32'h200;
        cnt_if = 0; cnt_mem = 0;
        repeat (30) begin
            tick();
            if (if_ready2) cnt_if++;
            if (mem_ready2) cnt_mem++;
        end
        mem_req2 = 0; if_req2 = 0;
        chk("nostarve_if_count", cnt_if, 0);
        chk("nostarve_mem_count", cnt_mem >= 9, 1);
        chk("nostarve_mem_rdata", mem_rdata2, data2(32'h100));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
